amstrad_mem_arbiter: RTL and testbench
======================================

Name: amstrad_mem_arbiter

Overview:
Shares the single 16-bit external RAM between three requesters: the Gate Array video fetch, the Z80 CPU, and the ROM/disk loader. It accepts one-deep pending requests from each requester, arbitrates among them, and maps byte-wide CPU and loader accesses onto 16-bit words with byte enables. It drives a req/ack RAM port and returns read data to the requester. It sits between the motherboard (mem_addr/vram_addr/cpu_dout) and the SDRAM controller.

Parameters:
VID_BASE, 22'h000000, word address added to vid_addr (video bank base)
LD_MAX_WAIT, 4, number of lost arbitrations after which the loader outranks the CPU (range 1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
cpu_req  in  1  one-cycle pulse: new CPU access
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  23  CPU byte address (mapped by MMU)
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data; held until next CPU read completes
cpu_done  out  1  one-cycle pulse: CPU access complete
vid_req  in  1  one-cycle pulse: video word fetch
vid_addr  in  15  video word address
vid_rdata  out  16  fetched video word; held
vid_valid  out  1  one-cycle pulse: vid_rdata updated
ld_req  in  1  one-cycle pulse: loader byte write
ld_addr  in  23  loader byte address
ld_wdata  in  8  loader data
ld_done  out  1  one-cycle pulse: loader write complete
ram_req  out  1  held high until ram_ack
ram_we  out  1  write strobe, stable while ram_req
ram_addr  out  22  word address
ram_be  out  2  byte enables, [1]=high byte
ram_wdata  out  16  write data
ram_ack  in  1  one-cycle pulse: access complete; ram_rdata valid in the same cycle
ram_rdata  in  16  read data
overrun  out  1  sticky: a request arrived while the same port was still pending

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0. Pending flags, starvation counter and FSM are cleared. An in-flight RAM access is abandoned, and ram_req drops on the next edge. A late ram_ack is ignored while in IDLE.
- Per-port pending latch: a req pulse sets pend_x and captures addr/we/data. A req arriving while pend_x=1 is dropped (first request kept) and sets overrun. A req arriving in the same cycle that port's completion pulse is emitted is accepted.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE: if any pend, select a winner and register ram_* (ram_req=1 on the next edge). Otherwise stay.
- ISSUE: ram_req=1 and all ram_* stable. Go to WAIT.
- WAIT: on ram_ack, drop ram_req, clear the winner's pend, latch read data, and go to IDLE. At most one access is outstanding.
- Priority: video > CPU > loader. Exception: when ld_starve >= LD_MAX_WAIT, the loader outranks the CPU, but never video.
- ld_starve: increments (saturating at 15) each time a grant is issued while pend_ld=1 and the loader loses. Resets to 0 when the loader is granted.
- Word mapping for CPU and loader:
  - ram_addr = byte_addr[22:1]
  - ram_be = addr[0] ? 2'b10 : 2'b01
  - ram_wdata = {wdata, wdata}
  - CPU read returns ram_rdata[15:8] if addr[0]=1, otherwise ram_rdata[7:0]. ram_be=2'b11 on reads.
- Video access: ram_addr = VID_BASE + vid_addr (22-bit, wraps mod 2^22), read only, ram_be=2'b11.
- Completion: cpu_done/vid_valid/ld_done pulse one cycle after the ram_ack edge. Data outputs are registered in the same edge as the pulse.
- Minimum turnaround: a grant can be issued from IDLE in the cycle after WAIT exits, so back-to-back accesses take 3 clk plus RAM latency.
- A CPU write followed by a CPU read of the same address returns the new data (accesses are strictly serialised in order per port).

Decomposition:
- Shared package amstrad_mem_pkg: port index constants (P_VID=0, P_CPU=1, P_LD=2), FSM state encoding, RAM_AW=22.
- One sub-module, amstrad_arb_prio: combinational winner select from pend[2:0], ld_starve and LD_MAX_WAIT. Kept separate so it can be unit-tested.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 clk with cpu_req pulsed -> all outputs 0, no ram_req after release.
- CPU write then read: write cpu_addr=23'h004001, wdata=8'hA5 -> ram_addr=22'h002000, ram_be=2'b10, ram_wdata=16'hA5A5, cpu_done 1 clk after ack. Then read with ram_rdata=16'hA512 -> cpu_rdata=8'hA5.
- Simultaneous requests: vid_req, cpu_req and ld_req in the same cycle -> grant order vid, cpu, ld. Three ram_req assertions. vid_valid occurs first.
- Loader starvation with LD_MAX_WAIT=2: keep the CPU re-requesting on every cpu_done while ld is pending -> the loader is granted on the 3rd arbitration, ahead of the pending CPU request.
- Overrun: second cpu_req while the first is still in WAIT -> overrun=1 (sticky), exactly one CPU RAM access, original address used.
- Reset mid-access: reset_n=0 during WAIT, then a late ram_ack -> no done/valid pulse, FSM in IDLE, pend cleared.

Source files
------------

// File: rtl/amstrad_mem_pkg.sv
// Shared constants for the Amstrad RAM arbiter: requester indices, FSM states, RAM geometry.
package amstrad_mem_pkg;

  localparam int RAM_AW = 22;

  localparam logic [1:0] P_VID = 2'd0;
  localparam logic [1:0] P_CPU = 2'd1;
  localparam logic [1:0] P_LD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Byte lane enable for a byte-wide write into a 16-bit word.
  function automatic logic [1:0] byte_be(input logic a0);
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/amstrad_arb_prio.sv
// Combinational winner select: video > CPU > loader, loader jumps the CPU once starved.
module amstrad_arb_prio
  import amstrad_mem_pkg::*;
#(
  parameter int LD_MAX_WAIT = 4
) (
  input  logic [2:0] pend,
  input  logic [3:0] ld_starve,
  output logic       gnt_vld,
  output logic [1:0] gnt_idx
);

  localparam logic [3:0] LD_MAX4 = 4'(LD_MAX_WAIT);

  always_comb begin
    gnt_vld = |pend;
    gnt_idx = P_VID;
    if (pend[P_VID]) begin
      gnt_idx = P_VID;
    end else if (pend[P_LD] && (!pend[P_CPU] || ld_starve >= LD_MAX4)) begin
      gnt_idx = P_LD;
    end else if (pend[P_CPU]) begin
      gnt_idx = P_CPU;
    end
  end

endmodule

// File: rtl/amstrad_mem_arbiter.sv
// Shares one 16-bit RAM between video, Z80 and loader; one access in flight, req held until ack.
// Completion pulses (and read data) appear the cycle after ram_ack; 3 clk + RAM latency per access.
module amstrad_mem_arbiter
  import amstrad_mem_pkg::*;
#(
  parameter logic [21:0] VID_BASE    = 22'h000000,
  parameter int          LD_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [22:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  input  logic              vid_req,
  input  logic [14:0]       vid_addr,
  output logic [15:0]       vid_rdata,
  output logic              vid_valid,
  input  logic              ld_req,
  input  logic [22:0]       ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_done,
  output logic              ram_req,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [1:0]        ram_be,
  output logic [15:0]       ram_wdata,
  input  logic              ram_ack,
  input  logic [15:0]       ram_rdata,
  output logic              overrun
);

  state_t      state, state_n;
  logic [2:0]  pend, pend_set, pend_clr;
  logic [3:0]  ld_starve;
  logic [1:0]  win;
  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic        grant, complete;

  logic [22:0] cpu_a;
  logic        cpu_w;
  logic [7:0]  cpu_d;
  logic [14:0] vid_a;
  logic [22:0] ld_a;
  logic [7:0]  ld_d;

  amstrad_arb_prio #(
    .LD_MAX_WAIT (LD_MAX_WAIT)
  ) u_prio (
    .pend      (pend),
    .ld_starve (ld_starve),
    .gnt_vld   (gnt_vld),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    complete = 1'b0;
    case (state)
      S_IDLE: begin
        grant = gnt_vld;
        if (gnt_vld) state_n = S_ISSUE;
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        complete = ram_ack;
        if (ram_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A request only lands in an empty slot; the slot empties on the ack edge, so a
  // request made in the ack cycle itself is dropped and flagged.
  always_comb begin
    pend_set = {ld_req & ~pend[P_LD], cpu_req & ~pend[P_CPU], vid_req & ~pend[P_VID]};
    pend_clr = '0;
    if (complete) pend_clr[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend      <= '0;
      ld_starve <= '0;
      win       <= P_VID;
      overrun   <= 1'b0;
      cpu_a     <= '0;
      cpu_w     <= 1'b0;
      cpu_d     <= '0;
      vid_a     <= '0;
      ld_a      <= '0;
      ld_d      <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_be    <= '0;
      ram_wdata <= '0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      vid_rdata <= '0;
      vid_valid <= 1'b0;
      ld_done   <= 1'b0;
    end else begin
      cpu_done  <= 1'b0;
      vid_valid <= 1'b0;
      ld_done   <= 1'b0;
      pend      <= (pend & ~pend_clr) | pend_set;
      overrun   <= overrun | (|({ld_req, cpu_req, vid_req} & pend));

      if (pend_set[P_CPU]) begin
        cpu_a <= cpu_addr;
        cpu_w <= cpu_we;
        cpu_d <= cpu_wdata;
      end
      if (pend_set[P_VID]) vid_a <= vid_addr;
      if (pend_set[P_LD]) begin
        ld_a <= ld_addr;
        ld_d <= ld_wdata;
      end

      if (grant) begin
        ram_req <= 1'b1;
        win     <= gnt_idx;
        case (gnt_idx)
          P_VID: begin
            ram_addr  <= VID_BASE + {7'd0, vid_a};
            ram_we    <= 1'b0;
            ram_be    <= 2'b11;
            ram_wdata <= '0;
          end
          P_CPU: begin
            ram_addr  <= cpu_a[22:1];
            ram_we    <= cpu_w;
            ram_be    <= cpu_w ? byte_be(cpu_a[0]) : 2'b11;
            ram_wdata <= {cpu_d, cpu_d};
          end
          default: begin
            ram_addr  <= ld_a[22:1];
            ram_we    <= 1'b1;
            ram_be    <= byte_be(ld_a[0]);
            ram_wdata <= {ld_d, ld_d};
          end
        endcase
        if (gnt_idx == P_LD)                       ld_starve <= '0;
        else if (pend[P_LD] && ld_starve != 4'hF) ld_starve <= ld_starve + 4'd1;
      end

      if (complete) begin
        ram_req <= 1'b0;
        case (win)
          P_VID: begin
            vid_valid <= 1'b1;
            vid_rdata <= ram_rdata;
          end
          P_CPU: begin
            cpu_done <= 1'b1;
            if (!cpu_w) cpu_rdata <= cpu_a[0] ? ram_rdata[15:8] : ram_rdata[7:0];
          end
          default: ld_done <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Directed plus random bench for amstrad_mem_arbiter with a request-level scoreboard and a RAM model.
module tb_amstrad_mem_arbiter;

  localparam logic [21:0] VB  = 22'h3FC000;
  localparam int          LMW = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, vid_req, ld_req, ram_ack;
  logic [22:0] cpu_addr, ld_addr;
  logic [7:0]  cpu_wdata, ld_wdata, cpu_rdata;
  logic [14:0] vid_addr;
  logic [15:0] vid_rdata, ram_wdata, ram_rdata;
  logic        cpu_done, vid_valid, ld_done, ram_req, ram_we, overrun;
  logic [21:0] ram_addr;
  logic [1:0]  ram_be;

  always #5 clk = ~clk;

  amstrad_mem_arbiter #(.VID_BASE(VB), .LD_MAX_WAIT(LMW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata), .overrun(overrun)
  );

  int checks = 0, passed = 0, fails = 0;

  // Scoreboard state: what each requester has outstanding, from the bench's point of view.
  logic [2:0]  pend_m;
  logic [22:0] cap_a [3];
  logic        cap_w [3];
  logic [7:0]  cap_d [3];
  int          starve_m, cur, lat;
  bit          busy, ovr_m, exp_grant, chk_wd;
  bit          ram_auto = 1'b1, rand_rd = 1'b1;
  logic [7:0]  cpu_rd_m;
  logic [15:0] vid_rd_m;
  logic [21:0] e_addr, last_addr;
  logic        e_we;
  logic [1:0]  e_be, last_be;
  logic [15:0] e_wd, last_wd;
  int          grant_log[$];
  int          done_log[$];
  logic [15:0] mem [logic [21:0]];
  logic [7:0]  shadow [logic [22:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int prio_m(input logic [2:0] p, input int s);
    if (p[0]) return 0;
    if (p[1] && p[2]) return (s >= LMW) ? 2 : 1;
    if (p[1]) return 1;
    if (p[2]) return 2;
    return -1;
  endfunction

  task automatic chk_fields();
    chk("ram_addr", {10'd0, ram_addr}, {10'd0, e_addr});
    chk("ram_we", {31'd0, ram_we}, {31'd0, e_we});
    chk("ram_be", {30'd0, ram_be}, {30'd0, e_be});
    if (chk_wd) chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, e_wd});
  endtask

  task automatic step();
    logic [2:0]  snap, reqs, acc;
    logic [15:0] wv;
    bit          comp;
    int          w;
    @(negedge clk);
    reqs = {ld_req, cpu_req, vid_req};
    comp = 1'b0;
    if (!reset_n) begin
      pend_m = '0; starve_m = 0; busy = 0; ovr_m = 0; exp_grant = 0; lat = 0;
      cpu_rd_m = '0; vid_rd_m = '0;
      chk("rst_ctl", {25'd0, ram_req, ram_we, ram_be, cpu_done, vid_valid, ld_done, overrun}, 0);
      chk("rst_ram", {ram_addr, ram_wdata[9:0]}, 0);
      chk("rst_rd", {8'd0, cpu_rdata, vid_rdata}, 0);
    end else begin
      snap = pend_m;
      comp = busy && ram_ack;
      if (comp) begin
        done_log.push_back(cur);
        chk("ack_drops_req", {31'd0, ram_req}, 0);
        if (cur == 0) vid_rd_m = ram_rdata;
        else if (cur == 1 && !cap_w[1]) cpu_rd_m = cap_a[1][0] ? ram_rdata[15:8] : ram_rdata[7:0];
        if (cur != 0 && (cur == 2 || cap_w[1])) shadow[cap_a[cur]] = cap_d[cur];
        if (cur == 1 && !cap_w[1] && rand_rd && shadow.exists(cap_a[1]))
          chk("rd_after_wr", {24'd0, cpu_rdata}, {24'd0, shadow[cap_a[1]]});
      end else if (busy) begin
        chk("req_held", {31'd0, ram_req}, 1);
        chk_fields();
      end else begin
        chk("grant_timing", {31'd0, ram_req}, {31'd0, exp_grant});
        w = prio_m(snap, starve_m);
        if (ram_req && w >= 0) begin
          grant_log.push_back(w);
          if (w == 0) begin
            e_addr = VB + {7'd0, cap_a[0][14:0]};
            e_we = 1'b0; e_be = 2'b11; e_wd = '0; chk_wd = 1'b0;
          end else begin
            e_addr = cap_a[w][22:1];
            e_we   = (w == 2) ? 1'b1 : cap_w[1];
            e_be   = e_we ? (cap_a[w][0] ? 2'b10 : 2'b01) : 2'b11;
            e_wd   = {cap_d[w], cap_d[w]};
            chk_wd = e_we;
          end
          chk_fields();
          last_addr = ram_addr; last_be = ram_be; last_wd = ram_wdata;
          if (w == 2) starve_m = 0;
          else if (snap[2]) starve_m = (starve_m < 15) ? starve_m + 1 : 15;
          busy = 1'b1; cur = w; lat = $urandom_range(4, 2);
        end
      end
      if (comp) busy = 1'b0;
      chk("vid_valid", {31'd0, vid_valid}, {31'd0, comp && cur == 0});
      chk("cpu_done", {31'd0, cpu_done}, {31'd0, comp && cur == 1});
      chk("ld_done", {31'd0, ld_done}, {31'd0, comp && cur == 2});
      chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_rd_m});
      chk("vid_rdata", {16'd0, vid_rdata}, {16'd0, vid_rd_m});
      acc = reqs & ~snap;
      if (|(reqs & snap)) ovr_m = 1'b1;
      if (comp) pend_m[cur] = 1'b0;
      pend_m = pend_m | acc;
      if (acc[0]) begin cap_a[0] = {8'd0, vid_addr}; cap_w[0] = 1'b0; cap_d[0] = '0; end
      if (acc[1]) begin cap_a[1] = cpu_addr; cap_w[1] = cpu_we; cap_d[1] = cpu_wdata; end
      if (acc[2]) begin cap_a[2] = ld_addr; cap_w[2] = 1'b1; cap_d[2] = ld_wdata; end
      chk("overrun", {31'd0, overrun}, {31'd0, ovr_m});
      exp_grant = !busy && (pend_m != 0);
    end
    vid_req = 1'b0; cpu_req = 1'b0; ld_req = 1'b0;
    if (ram_auto) begin
      ram_ack = 1'b0;
      if (busy && lat > 0) begin
        lat--;
        if (lat == 0) begin
          ram_ack = 1'b1;
          if (!mem.exists(ram_addr)) mem[ram_addr] = 16'($urandom);
          wv = mem[ram_addr];
          if (ram_we) begin
            if (ram_be[0]) wv[7:0]  = ram_wdata[7:0];
            if (ram_be[1]) wv[15:8] = ram_wdata[15:8];
            mem[ram_addr] = wv;
          end else if (rand_rd) begin
            ram_rdata = wv;
          end
        end
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    bit ok;
    while ((busy || pend_m != 0) && n < maxc) begin
      step();
      n++;
    end
    ok = !(busy || pend_m != 0);
    chk("drain_done", {31'd0, ok}, 1);
  endtask

  task automatic wait_busy(input int maxc);
    int n = 0;
    while (!busy && n < maxc) begin
      step();
      n++;
    end
    chk("grant_seen", {31'd0, busy}, 1);
  endtask

  initial begin
    int vre, cre;
    reset_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0; ld_req = 0; ld_addr = '0; ld_wdata = '0;
    ram_ack = 0; ram_rdata = '0;

    // Reset with a CPU request pulsed inside it: nothing may be remembered.
    step();
    cpu_req = 1'b1; cpu_addr = 23'h000042;
    step(); step();
    reset_n = 1'b1;
    repeat (4) step();

    // CPU write then read of the same odd byte.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h004001; cpu_wdata = 8'hA5;
    step();
    drain(40);
    chk("wr_addr", {10'd0, last_addr}, 32'h002000);
    chk("wr_be", {30'd0, last_be}, 2);
    chk("wr_wdata", {16'd0, last_wd}, 32'hA5A5);
    rand_rd = 1'b0; ram_rdata = 16'hA512;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h004001;
    step();
    drain(40);
    step();
    chk("rd_byte", {24'd0, cpu_rdata}, 32'hA5);
    chk("rd_be", {30'd0, last_be}, 3);
    rand_rd = 1'b1;

    // Simultaneous requests, including video base wrap.
    grant_log.delete(); done_log.delete();
    vid_req = 1'b1; vid_addr = 15'h7FFF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000007;
    ld_req = 1'b1; ld_addr = 23'h000006; ld_wdata = 8'h5A;
    step();
    drain(80);
    chk("sim_grants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("sim_g0", grant_log[0], 0);
      chk("sim_g1", grant_log[1], 1);
      chk("sim_g2", grant_log[2], 2);
    end
    if (done_log.size() > 0) chk("sim_first_done", done_log[0], 0);

    // Loader starvation: video and CPU keep re-requesting on completion.
    grant_log.delete();
    vre = 0; cre = 0;
    vid_req = 1'b1; vid_addr = 15'h0010;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000002; cpu_wdata = 8'h11;
    ld_req = 1'b1; ld_addr = 23'h000003; ld_wdata = 8'h22;
    step();
    for (int i = 0; i < 150 && (busy || pend_m != 0); i++) begin
      step();
      if (vid_valid && vre < 1) begin vid_req = 1'b1; vid_addr = 15'h0011; vre++; end
      if (cpu_done && cre < 1) begin cpu_req = 1'b1; cpu_addr = 23'h000004; cpu_wdata = 8'h33; cre++; end
    end
    drain(40);
    chk("starve_grants", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      chk("starve_g1_cpu", grant_log[1], 1);
      chk("starve_g3_ld", grant_log[3], 2);
      chk("starve_g4_cpu", grant_log[4], 1);
    end

    // Overrun: second CPU request while the first is in flight.
    grant_log.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000123;
    step();
    wait_busy(10);
    cpu_req = 1'b1; cpu_addr = 23'h000456;
    step();
    drain(40);
    repeat (3) step();
    chk("ovr_sticky", {31'd0, overrun}, 1);
    chk("ovr_one_access", grant_log.size(), 1);
    chk("ovr_orig_addr", {10'd0, last_addr}, 32'h000091);

    // Reset during WAIT, then a late ack.
    ram_auto = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000010; cpu_wdata = 8'h3C;
    step();
    wait_busy(10);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; ram_ack = 1'b1;
    step();
    chk("late_ack_no_done", {29'd0, cpu_done, vid_valid, ld_done}, 0);
    ram_ack = 1'b0;
    repeat (3) step();
    chk("rst_mid_idle", {31'd0, ram_req}, 0);
    ram_auto = 1'b1;

    // Random traffic against the scoreboard.
    for (int i = 0; i < 500; i++) begin
      if (!pend_m[0] && $urandom_range(3, 0) == 0) begin
        vid_req = 1'b1; vid_addr = 15'($urandom);
      end
      if (!pend_m[1] && $urandom_range(2, 0) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 23'($urandom_range(15, 0));
        cpu_wdata = 8'($urandom);
      end
      if (!pend_m[2] && $urandom_range(3, 0) == 0) begin
        ld_req = 1'b1; ld_addr = 23'($urandom_range(15, 0)); ld_wdata = 8'($urandom);
      end
      step();
    end
    drain(100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
